// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if -- bundle between the pixel-drawing engines, the
// plot arbiter and the vga_adapter write port.
//
// Signals (engine i owns bit i / field [i*W +: W] of the packed buses):
//   req        engine request, level
//   pix_valid  engine pixel strobe
//   pix_last   last pixel of the burst, sampled with pix_valid
//   pix_x/y/colour  packed per-engine pixel fields
//   gnt        one-hot grant back to the engines
//   out_x/out_y/out_colour/plot  to vga_adapter
//   busy       arbiter is inside a burst
//   timeout_err  one-cycle pulse on a timed-out grant
//
// Modports: slave = arbiter side, master = engines/adapter side.
interface plot_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int XW      = 9,
   parameter int YW      = 8,
   parameter int CW      = 3
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    pix_valid;
   logic [NUM_REQ-1:0]    pix_last;
   logic [NUM_REQ*XW-1:0] pix_x;
   logic [NUM_REQ*YW-1:0] pix_y;
   logic [NUM_REQ*CW-1:0] pix_colour;
   logic [NUM_REQ-1:0]    gnt;
   logic [XW-1:0]         out_x;
   logic [YW-1:0]         out_y;
   logic [CW-1:0]         out_colour;
   logic                  plot;
   logic                  busy;
   logic                  timeout_err;

   modport slave (
      input  req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
      output gnt, out_x, out_y, out_colour, plot, busy, timeout_err
   );

   modport master (
      output req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
      input  gnt, out_x, out_y, out_colour, plot, busy, timeout_err
   );
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter -- round-robin arbiter sharing the single vga_adapter
// write port among NUM_REQ pixel-drawing engines.
//
// An engine raises req, receives a registered one-hot gnt and streams
// pixels (pix_valid) until it flags pix_last. Each accepted pixel of the
// granted engine appears on out_x/out_y/out_colour with plot=1 one cycle
// later. A burst also ends if the engine drops req (abort) or stays silent
// for TIMEOUT cycles (revoke, timeout_err pulse). Every burst end passes
// through IDLE, so gnt is low for at least one cycle between bursts.
//
// Ports:
//   clock   system clock
//   resetn  asynchronous active-low reset
//   bus     plot_arbiter_if.slave (engine requests/pixels in, grant and
//           vga_adapter write port out)
//
// Build option: define CLIP_EN to suppress plotting of pixels with
// x >= 320 or y >= 240 (the pixel is still consumed and pix_last honoured).
module plot_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int XW      = 9,
   parameter int YW      = 8,
   parameter int CW      = 3,
   parameter int TIMEOUT = 255
) (
   input  logic          clock,
   input  logic          resetn,
   plot_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   // counter value at which the next silent cycle hits TIMEOUT
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               r_state, w_state_nxt;
   logic [IW-1:0]        r_last,  w_last_nxt;
   logic [NUM_REQ-1:0]   r_gnt,   w_gnt_nxt;
   logic [7:0]           r_idle,  w_idle_nxt;
   logic [XW-1:0]        r_x,     w_x_nxt;
   logic [YW-1:0]        r_y,     w_y_nxt;
   logic [CW-1:0]        r_c,     w_c_nxt;
   logic                 r_plot,  w_plot_nxt;
   logic                 r_tmo,   w_tmo_nxt;

   // per-engine views of the packed pixel buses
   logic [NUM_REQ-1:0][XW-1:0] w_px;
   logic [NUM_REQ-1:0][YW-1:0] w_py;
   logic [NUM_REQ-1:0][CW-1:0] w_pc;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign w_px[i] = bus.pix_x[i*XW +: XW];
      assign w_py[i] = bus.pix_y[i*YW +: YW];
      assign w_pc[i] = bus.pix_colour[i*CW +: CW];
   end

   // granted engine (r_last holds it for the whole burst)
   logic          w_gv, w_gl, w_gr, w_clip, w_vis;
   logic [XW-1:0] w_gx;
   logic [YW-1:0] w_gy;
   logic [CW-1:0] w_gc;

   assign w_gv = bus.pix_valid[r_last];
   assign w_gl = bus.pix_last[r_last];
   assign w_gr = bus.req[r_last];
   assign w_gx = w_px[r_last];
   assign w_gy = w_py[r_last];
   assign w_gc = w_pc[r_last];

`ifdef CLIP_EN
   localparam logic [XW:0] CLIP_X = (XW+1)'(320);
   localparam logic [YW:0] CLIP_Y = (YW+1)'(240);
   assign w_clip = ({1'b0, w_gx} >= CLIP_X) | ({1'b0, w_gy} >= CLIP_Y);
`else
   assign w_clip = 1'b0;
`endif

   assign w_vis = w_gv & ~w_clip;

   // round-robin search starting just after the previous winner
   logic          w_found;
   logic [IW-1:0] w_win, w_idx;

   always_comb begin
      w_found = 1'b0;
      w_win   = r_last;
      w_idx   = r_last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = IW'((int'(r_last) + k) % NUM_REQ);
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   // next-state / next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_gnt_nxt   = r_gnt;
      w_idle_nxt  = r_idle;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_c_nxt     = r_c;
      w_plot_nxt  = 1'b0;
      w_tmo_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            w_gnt_nxt = '0;
            if (w_found) begin
               w_state_nxt = BURST;
               w_gnt_nxt   = NUM_REQ'(1) << w_win;
               w_last_nxt  = w_win;
               w_idle_nxt  = 8'd0;
            end
         end
         BURST: begin
            if (w_gv) begin
               w_idle_nxt = 8'd0;
               if (w_vis) begin
                  w_plot_nxt = 1'b1;
                  w_x_nxt    = w_gx;
                  w_y_nxt    = w_gy;
                  w_c_nxt    = w_gc;
               end
            end else begin
               w_idle_nxt = r_idle + 8'd1;
            end

            // last wins over abort; abort wins over timeout
            if (w_gv && w_gl) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
            end else if (!w_gr) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
            end else if (!w_gv && r_idle == TMO_LAST) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_tmo_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_last  <= IW'(NUM_REQ - 1);
         r_gnt   <= '0;
         r_idle  <= 8'd0;
         r_x     <= '0;
         r_y     <= '0;
         r_c     <= '0;
         r_plot  <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_gnt   <= w_gnt_nxt;
         r_idle  <= w_idle_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_c     <= w_c_nxt;
         r_plot  <= w_plot_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   assign bus.gnt         = r_gnt;
   assign bus.out_x       = r_x;
   assign bus.out_y       = r_y;
   assign bus.out_colour  = r_c;
   assign bus.plot        = r_plot;
   assign bus.busy        = (r_state == BURST);
   assign bus.timeout_err = r_tmo;
endmodule
